cnt_updn: RTL and testbench
===========================

CNT_UPDN -- requirements
Module: cnt_updn

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 8, count range 0..MODULUS-1.
- Legal range: 2 <= MODULUS <= 2^WIDTH.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrap at ends, 1 = saturate at ends.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port clr_ovf  input  1  clears sticky overflow flag.
REQ-011 SHALL have port y  output  WIDTH  registered count value.
REQ-012 SHALL have port tc  output  1  combinational terminal-count indication.
REQ-013 SHALL have port wrap  output  1  registered one-cycle end-event pulse.
REQ-014 SHALL have port ovf  output  1  sticky end-event flag.
REQ-015 SHALL have port gray  output  WIDTH  Gray-coded count; exists only under CNT_GRAY_OUT_EN.

Function
REQ-016 SHALL apply per-edge priority rst > load > en; en=0 with load=0 holds y.
REQ-017 SHALL load y <= load_val on load=1 when load_val <= MODULUS-1.
- load_val >= MODULUS loads MODULUS-1 (clamp).
- A load never produces a wrap pulse and never sets ovf.
REQ-018 SHALL set y <= y+1 when en=1 and up=1 and y < MODULUS-1.
- Same conditions with up=0 and y > 0: y <= y-1.
REQ-019 SHALL define an end event as en=1, load=0, and either up=1 with y == MODULUS-1 or up=0 with y == 0.
REQ-020 SHALL, on an end event with SAT=0, set y to 0 (counting up) or MODULUS-1 (counting down).
REQ-021 SHALL, on an end event with SAT=1, hold y unchanged.
REQ-022 SHALL drive tc=1 exactly when the current-cycle inputs and y form an end event (zero latency).
REQ-023 SHALL assert wrap for exactly the one cycle following each end event, in both SAT modes.
REQ-024 SHALL set ovf on the edge of an end event and hold it until the edge on which clr_ovf=1.
- End event coincident with clr_ovf=1: set wins, ovf stays 1.
REQ-025 SHALL never let y leave 0..MODULUS-1 under any input sequence.
REQ-026 SHALL treat a direction change as taking effect on the same edge, with no dead cycle.

Reset
REQ-027 SHALL, on any edge with rst=1, force y=0, wrap=0, ovf=0 and gray=0, overriding load, en and clr_ovf.
REQ-028 SHALL, on rst asserted mid-count, reach the reset state on that edge, with no wrap pulse afterwards.
REQ-029 SHALL resume normal operation on the first edge with rst=0.

Configuration
REQ-030 SHALL use macro CNT_GRAY_OUT_EN to control the Gray output.
- Defined: port gray exists; registered alongside y; gray == y ^ (y >> 1) on every cycle, with no extra latency.
- Undefined: port gray and its register are absent; all other behaviour is identical.

Structure
REQ-031 SHALL place bin2gray function and end-event direction constants in shared package cnt_pkg, included by RTL and bench.
REQ-032 SHALL implement the Gray encoder as sub-module cnt_bin2gray, parameterised by WIDTH; the counter core stays in cnt_updn.

Verification (WIDTH=3, MODULUS=6 unless stated)
REQ-033 SHALL cover: rst 2 cycles, en=1, up=1 for 8 cycles.
- y = 0,1,2,3,4,5,0,1.
- tc high only while y=5.
- wrap high the cycle y returns to 0.
- ovf=1 thereafter.
REQ-034 SHALL cover down-counting with SAT=1 from load_val=2.
- y = 2,1,0,0,0.
- wrap pulses once per held cycle at 0.
- y never equals 7.
REQ-035 SHALL cover load_val=7.
- y=5 next cycle.
- Same edge with en=1, up=1 at y=5: load wins, y=5, no wrap.
REQ-036 SHALL cover end event coincident with clr_ovf=1.
- ovf stays 1.
- Next cycle clr_ovf=1 alone: ovf=0.
REQ-037 SHALL cover rst=1 at y=5 with en=1, up=1.
- Next cycle: y=0, wrap=0, ovf=0.
REQ-038 SHALL cover, with CNT_GRAY_OUT_EN and WIDTH=4, MODULUS=16, a full up-count.
- gray = 0,1,3,2,6,...,8.
- Successive values differ by exactly one bit, including across the wrap.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for the cnt_updn counter: direction encodings, next-state
// action type and the binary-to-Gray helper used by RTL and bench.
package cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STEP,
    ACT_END
  } act_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cnt_bin2gray.sv
// Combinational binary-to-Gray encoder. Only built when CNT_GRAY_OUT_EN is
// defined, since the counter instantiates it only in that configuration.
`ifdef CNT_GRAY_OUT_EN
module cnt_bin2gray
  import cnt_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = WIDTH'(bin2gray(32'(i_bin)));

endmodule
`endif

// File: rtl/cnt_updn.sv
// Modulo up/down counter with clamped load, wrap/saturate ends, end-event pulse
// and sticky flag. Optional Gray output port under macro CNT_GRAY_OUT_EN.
module cnt_updn
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
`ifdef CNT_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_next;
  logic             r_wrap;
  logic             r_ovf;
  logic             w_end;
  act_e             w_act;

  // A load on the same edge masks the end event, so it never pulses wrap.
  always_comb begin
    w_end = en && !load &&
            (((up == DIR_UP) && (r_y == MAX_V)) || ((up == DIR_DN) && (r_y == '0)));
    if (load)       w_act = ACT_LOAD;
    else if (!en)   w_act = ACT_HOLD;
    else if (w_end) w_act = ACT_END;
    else            w_act = ACT_STEP;
  end

  always_comb begin
    w_y_next = r_y;
    case (w_act)
      ACT_LOAD: w_y_next = (load_val > MAX_V) ? MAX_V : load_val;
      ACT_STEP: w_y_next = (up == DIR_UP) ? r_y + WIDTH'(1) : r_y - WIDTH'(1);
      ACT_END: begin
        if (SAT == 0) w_y_next = (up == DIR_UP) ? '0 : MAX_V;
      end
      default: w_y_next = r_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_y    <= w_y_next;
      r_wrap <= w_end;
      if (w_end)        r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign y    = r_y;
  assign tc   = w_end;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;

`ifdef CNT_GRAY_OUT_EN
  // Encode the next count so the Gray register tracks y with no extra latency.
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] r_gray;

  cnt_bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (w_y_next),
    .o_gray (w_gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_gray <= '0;
    else     r_gray <= w_gray_next;
  end

  assign gray = r_gray;
`endif

endmodule

// File: tb/tb_cnt_updn.sv
// Scoreboard bench for cnt_updn: directed rows push expectations, a negedge
// monitor pops and compares. Gray section active under CNT_GRAY_OUT_EN.
module tb_cnt_updn;
  import cnt_pkg::*;

  typedef struct {
    logic       rst, en, up, ld;
    logic [2:0] lv;
    logic       clr, chk;
    logic [2:0] y;
    logic       tc, wrap, ovf;
  } row_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] y;
    logic       tc, wrap, ovf;
    logic [3:0] gray;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up, ld, clr;
  logic [2:0] lv;
  logic [3:0] lv4 = 4'd0;
  logic [2:0] y0, y1;
  logic       tc0, tc1, wrap0, wrap1, ovf0, ovf1;
  logic [3:0] y2;
  logic       tc2, wrap2, ovf2;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t e;
  logic [3:0] prev_g;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

`ifdef CNT_GRAY_OUT_EN
  logic [2:0] gray0, gray1;
  logic [3:0] gray2;
`endif

  cnt_updn #(.WIDTH(3), .MODULUS(6), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(ld), .load_val(lv), .clr_ovf(clr),
    .y(y0), .tc(tc0), .wrap(wrap0), .ovf(ovf0)
`ifdef CNT_GRAY_OUT_EN
    , .gray(gray0)
`endif
  );

  cnt_updn #(.WIDTH(3), .MODULUS(6), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(ld), .load_val(lv), .clr_ovf(clr),
    .y(y1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
`ifdef CNT_GRAY_OUT_EN
    , .gray(gray1)
`endif
  );

`ifdef CNT_GRAY_OUT_EN
  cnt_updn #(.WIDTH(4), .MODULUS(16), .SAT(0)) dut_gray (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(ld), .load_val(lv4), .clr_ovf(clr),
    .y(y2), .tc(tc2), .wrap(wrap2), .ovf(ovf2), .gray(gray2)
  );
`else
  assign y2 = 4'd0; assign tc2 = 1'b0; assign wrap2 = 1'b0; assign ovf2 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic row_t mk(input logic r, input logic n, input logic u, input logic l,
                              input int v, input logic c, input logic k, input int yy,
                              input logic t, input logic w, input logic o);
    row_t rw;
    rw.rst = r; rw.en = n; rw.up = u; rw.ld = l; rw.lv = 3'(v); rw.clr = c; rw.chk = k;
    rw.y = 3'(yy); rw.tc = t; rw.wrap = w; rw.ovf = o;
    return rw;
  endfunction

  // Row expectations describe the cycle in which the row's inputs are applied.
  task automatic apply(input int id, input row_t rw);
    exp_t x;
    @(posedge clk);
    #1;
    rst = rw.rst; en = rw.en; up = rw.up; ld = rw.ld; lv = rw.lv; clr = rw.clr;
    if (rw.chk) begin
      x.cyc = cyc; x.id = id; x.y = {1'b0, rw.y}; x.tc = rw.tc; x.wrap = rw.wrap;
      x.ovf = rw.ovf; x.gray = 4'd0; x.first = 1'b0;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) chk("stale_entry", e.cyc, cyc);
      else begin
        case (e.id)
          0: begin
            chk("wrap_y", y0, e.y); chk("wrap_tc", tc0, e.tc);
            chk("wrap_wrap", wrap0, e.wrap); chk("wrap_ovf", ovf0, e.ovf);
            chk("wrap_range", y0 < 3'd6, 1);
          end
          1: begin
            chk("sat_y", y1, e.y); chk("sat_tc", tc1, e.tc);
            chk("sat_wrap", wrap1, e.wrap); chk("sat_ovf", ovf1, e.ovf);
            chk("sat_range", y1 < 3'd6, 1);
          end
          default: begin
            chk("g16_y", y2, e.y);
`ifdef CNT_GRAY_OUT_EN
            chk("g16_gray", gray2, e.gray);
            if (!e.first) chk("g16_onebit", $countones(gray2 ^ prev_g), 1);
            prev_g = gray2;
`endif
          end
        endcase
      end
    end
  end

  row_t seq_a[26];
  row_t seq_b[13];

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; lv = 3'd0; clr = 1'b0;
    prev_g = 4'd0;
    //                 rst en up ld lv clr chk  y tc wr ov
    seq_a[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seq_a[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    seq_a[2]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq_a[3]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    seq_a[4]  = mk(0, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    seq_a[5]  = mk(0, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    seq_a[6]  = mk(0, 1, 1, 0, 0, 0, 1, 4, 0, 0, 0);
    seq_a[7]  = mk(0, 1, 1, 0, 0, 0, 1, 5, 1, 0, 0);
    seq_a[8]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    seq_a[9]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    seq_a[10] = mk(0, 0, 0, 1, 7, 0, 1, 2, 0, 0, 1);
    seq_a[11] = mk(0, 1, 1, 1, 7, 0, 1, 5, 0, 0, 1);
    seq_a[12] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1);
    seq_a[13] = mk(0, 1, 1, 0, 0, 1, 1, 5, 1, 0, 1);
    seq_a[14] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
    seq_a[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    seq_a[16] = mk(0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 0);
    seq_a[17] = mk(1, 1, 1, 0, 0, 0, 1, 5, 1, 0, 0);
    seq_a[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    seq_a[19] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    seq_a[20] = mk(0, 1, 1, 0, 0, 0, 1, 5, 1, 1, 1);
    seq_a[21] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    seq_a[22] = mk(0, 1, 0, 0, 0, 0, 1, 5, 0, 1, 1);
    seq_a[23] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    seq_a[24] = mk(0, 1, 0, 1, 3, 0, 1, 4, 0, 0, 1);
    seq_a[25] = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1);

    seq_b[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seq_b[1]  = mk(0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0);
    seq_b[2]  = mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    seq_b[3]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    seq_b[4]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    seq_b[5]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    seq_b[6]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    seq_b[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    seq_b[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    seq_b[9]  = mk(0, 0, 0, 1, 7, 0, 1, 0, 0, 0, 1);
    seq_b[10] = mk(0, 1, 1, 0, 0, 0, 1, 5, 1, 0, 1);
    seq_b[11] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1);
    seq_b[12] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1);

    foreach (seq_a[i]) apply(0, seq_a[i]);
    foreach (seq_b[i]) apply(1, seq_b[i]);

`ifdef CNT_GRAY_OUT_EN
    begin
      logic [3:0] gt [17];
      exp_t x;
      gt = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
             4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; ld = 1'b0; clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; up = DIR_UP;
        x.cyc = cyc; x.id = 2; x.y = 4'(i % 16); x.tc = 1'b0; x.wrap = 1'b0;
        x.ovf = 1'b0; x.gray = gt[i]; x.first = (i == 0);
        sb.push_back(x);
      end
      @(posedge clk); #1;
      en = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
